// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter: FSM state, requester id, tag stage.
package bram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Byte address sits above three bit-select LSBs on the DPB address bus in 8-bit mode.
    localparam int AD_SHIFT = 3;

    typedef struct packed {
        logic    vld;
        req_id_e id;
    } tag_t;

endpackage

// File: rtl/bram_arb_rr.sv
// Two-way round-robin grant; combinational grant, registered last-grant (resets to requester 1).
module bram_arb_rr
    import bram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] vld_i,
    output logic [1:0] gnt_o
);

    req_id_e last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&vld_i) begin
                gnt_o = (last_q == REQ1) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = vld_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= REQ1;
        end else if (gnt_o[0]) begin
            last_q <= REQ0;
        end else if (gnt_o[1]) begin
            last_q <= REQ1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates two byte-wide requesters onto one DPB port; reads return READ_LATENCY+1 cycles after transfer.
// Define BRAM_PORT_ARBITER_CLEAR_EN to zero the whole memory in INIT after every reset.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic              REQ0_WE,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [7:0]        REQ0_WDATA,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic              REQ1_WE,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [7:0]        REQ1_WDATA,
    output logic              RSP0_VALID,
    output logic [7:0]        RSP0_RDATA,
    output logic              RSP1_VALID,
    output logic [7:0]        RSP1_RDATA,
    output logic              MEM_CE,
    output logic              MEM_OCE,
    output logic              MEM_WRE,
    output logic [13:0]       MEM_AD,
    output logic [15:0]       MEM_DI,
    output logic [2:0]        MEM_BLKSEL,
    output logic              MEM_RESET,
    input  logic [15:0]       MEM_DO
);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("bram_port_arbiter: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    state_e                  state_q;
    logic                    run_en;
    logic [1:0]              gnt;
    logic                    xfer;
    req_id_e                 sel_id;
    logic                    we_sel;
    logic [ADDR_W-1:0]       addr_sel;
    logic [7:0]              wdata_sel;
    logic                    init_wr;
    logic [ADDR_W-1:0]       init_addr;
    tag_t                    tag_in;
    tag_t [READ_LATENCY:0]   tag_q;
    tag_t                    cap;
    logic [7:0]              rdata0_q;
    logic [7:0]              rdata1_q;
    logic                    mem_reset_q;
    logic                    unused_do_hi;

    // RESETN gating keeps requesters and INIT writes off the port while reset is held.
    assign run_en = RESETN && (state_q == ST_RUN);

    bram_arb_rr u_rr (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .en_i   (run_en),
        .vld_i  ({REQ1_VALID, REQ0_VALID}),
        .gnt_o  (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign xfer       = |gnt;
    assign sel_id     = gnt[1] ? REQ1 : REQ0;
    assign we_sel     = gnt[1] ? REQ1_WE    : REQ0_WE;
    assign addr_sel   = gnt[1] ? REQ1_ADDR  : REQ0_ADDR;
    assign wdata_sel  = gnt[1] ? REQ1_WDATA : REQ0_WDATA;

`ifdef BRAM_PORT_ARBITER_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q;

    assign init_wr   = RESETN && (state_q == ST_INIT);
    assign init_addr = cnt_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end
`else
    assign init_wr   = 1'b0;
    assign init_addr = '0;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= ST_RUN;
        end
    end
`endif

    assign MEM_CE     = xfer || init_wr;
    assign MEM_WRE    = (xfer && we_sel) || init_wr;
    assign MEM_AD     = init_wr ? (14'(init_addr) << AD_SHIFT) : (14'(addr_sel) << AD_SHIFT);
    assign MEM_DI     = init_wr ? 16'h0000 : {8'h00, wdata_sel};
    assign MEM_OCE    = 1'b1;
    assign MEM_BLKSEL = 3'b000;
    assign MEM_RESET  = mem_reset_q;
    assign unused_do_hi = ^MEM_DO[15:8];

    assign tag_in.vld = xfer && !we_sel;
    assign tag_in.id  = sel_id;

    // Stage READ_LATENCY-1 lines up with the edge at which the DPB output holds this read's data.
    assign cap = tag_q[READ_LATENCY-1];

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            tag_q    <= '0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            tag_q <= {tag_q[READ_LATENCY-1:0], tag_in};
            if (cap.vld && cap.id == REQ0) begin
                rdata0_q <= MEM_DO[7:0];
            end
            if (cap.vld && cap.id == REQ1) begin
                rdata1_q <= MEM_DO[7:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        mem_reset_q <= !RESETN;
    end

    assign RSP0_VALID = tag_q[READ_LATENCY].vld && (tag_q[READ_LATENCY].id == REQ0);
    assign RSP1_VALID = tag_q[READ_LATENCY].vld && (tag_q[READ_LATENCY].id == REQ1);
    assign RSP0_RDATA = rdata0_q;
    assign RSP1_RDATA = rdata1_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives two arbiters (READ_LATENCY 1 and 2) in lockstep, each with its own 8-bit DPB model.
module tb_bram_port_arbiter;

`ifdef BRAM_PORT_ARBITER_CLEAR_EN
    localparam int        INIT_N = 2048;
    localparam logic [7:0] FILL  = 8'hA5;
    localparam bit        CLR    = 1'b1;
`else
    localparam int        INIT_N = 1;
    localparam logic [7:0] FILL  = 8'h00;
    localparam bit        CLR    = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        q0v, q0w, q1v, q1w;
    logic [10:0] q0a, q1a;
    logic [7:0]  q0d, q1d;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic        rv0  [2];
    logic        rv1  [2];
    logic [7:0]  rd0  [2];
    logic [7:0]  rd1  [2];
    logic        ce   [2];
    logic        oce  [2];
    logic        wre  [2];
    logic [13:0] ad   [2];
    logic [15:0] di   [2];
    logic [2:0]  blk  [2];
    logic        mrst [2];
    logic [15:0] mdo  [2];

    int errs   = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [2048];
        logic [7:0] dout_r;
        logic [7:0] dout_p;

        initial begin
            for (int i = 0; i < 2048; i++) mem[i] = FILL;
        end

        always @(posedge CLK) begin
            if (mrst[g]) begin
                dout_r <= 8'h00;
                dout_p <= 8'h00;
            end else begin
                if (ce[g]) begin
                    if (wre[g]) mem[ad[g][13:3]] <= di[g][7:0];
                    else        dout_r <= mem[ad[g][13:3]];
                end
                if (oce[g]) dout_p <= dout_r;
            end
        end

        assign mdo[g] = {8'h00, (g == 0) ? dout_r : dout_p};

        bram_port_arbiter #(.ADDR_W(11), .READ_LATENCY(g + 1)) u_dut (
            .CLK        (CLK),
            .RESETN     (RESETN),
            .REQ0_VALID (q0v),
            .REQ0_READY (rdy0[g]),
            .REQ0_WE    (q0w),
            .REQ0_ADDR  (q0a),
            .REQ0_WDATA (q0d),
            .REQ1_VALID (q1v),
            .REQ1_READY (rdy1[g]),
            .REQ1_WE    (q1w),
            .REQ1_ADDR  (q1a),
            .REQ1_WDATA (q1d),
            .RSP0_VALID (rv0[g]),
            .RSP0_RDATA (rd0[g]),
            .RSP1_VALID (rv1[g]),
            .RSP1_RDATA (rd1[g]),
            .MEM_CE     (ce[g]),
            .MEM_OCE    (oce[g]),
            .MEM_WRE    (wre[g]),
            .MEM_AD     (ad[g]),
            .MEM_DI     (di[g]),
            .MEM_BLKSEL (blk[g]),
            .MEM_RESET  (mrst[g]),
            .MEM_DO     (mdo[g])
        );
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [10:0] a0, input logic [7:0] d0,
                         input logic v1, input logic w1, input logic [10:0] a1, input logic [7:0] d1);
        q0v = v0; q0w = w0; q0a = a0; q0d = d0;
        q1v = v1; q1w = w1; q1a = a1; q1d = d1;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rdy(input string tag, input logic e0, input logic e1);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s.rdy0[%0d]", tag, g), rdy0[g], e0);
            chk($sformatf("%s.rdy1[%0d]", tag, g), rdy1[g], e1);
        end
    endtask

    task automatic rsp(input string tag, input int g, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1);
        chk($sformatf("%s.rv0[%0d]", tag, g), rv0[g], v0);
        chk($sformatf("%s.rd0[%0d]", tag, g), rd0[g], d0);
        chk($sformatf("%s.rv1[%0d]", tag, g), rv1[g], v1);
        chk($sformatf("%s.rd1[%0d]", tag, g), rd1[g], d1);
    endtask

    task automatic mem_if(input string tag, input logic e_ce, input logic e_wre,
                          input logic [13:0] e_ad, input logic [15:0] e_di);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s.ce[%0d]", tag, g), ce[g], e_ce);
            chk($sformatf("%s.wre[%0d]", tag, g), wre[g], e_wre);
            if (e_ce) begin
                chk($sformatf("%s.ad[%0d]", tag, g), ad[g], e_ad);
                chk($sformatf("%s.di[%0d]", tag, g), di[g], e_di);
            end
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!rdy0[0] && !rdy1[0] && n < 4000) begin
            tick();
            n++;
        end
        chk({tag, ".init_len"}, 16'(n), 16'(INIT_N));
    endtask

    task automatic reset_state(input string tag);
        for (int g = 0; g < 2; g++) begin
            rsp(tag, g, 0, 8'h00, 0, 8'h00);
            chk($sformatf("%s.mrst[%0d]", tag, g), mrst[g], 1'b1);
            chk($sformatf("%s.oce[%0d]", tag, g), oce[g], 1'b1);
            chk($sformatf("%s.blk[%0d]", tag, g), blk[g], 3'b000);
        end
        rdy(tag, 0, 0);
        mem_if(tag, 0, 0, 0, 0);
    endtask

    initial begin
        logic [7:0] x0, x1;
        x0 = CLR ? 8'h00 : 8'hBE;
        x1 = CLR ? 8'h00 : 8'hDA;

        // Reset with requests pending: they must be ignored.
        RESETN = 1'b0;
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        repeat (3) tick();
        reset_state("rst");

        // First read of address 0 by requester 0, straight after INIT.
        RESETN = 1'b1;
        drive(1, 0, 11'd0, 8'h00, 0, 0, 0, 0);
        wait_init("boot");
        rdy("t1", 1, 0);
        mem_if("t1", 1, 0, 14'h0000, 16'h0000);
        tick();
        idle();
        mem_if("t1.idle", 0, 0, 0, 0);
        rsp("t1.c0", 0, 0, 8'h00, 0, 8'h00);
        rsp("t1.c0", 1, 0, 8'h00, 0, 8'h00);
        tick();
        rsp("t1.c1", 0, 1, 8'h00, 0, 8'h00);
        rsp("t1.c1", 1, 0, 8'h00, 0, 8'h00);
        tick();
        rsp("t1.c2", 0, 0, 8'h00, 0, 8'h00);
        rsp("t1.c2", 1, 1, 8'h00, 0, 8'h00);
        tick();
        rsp("t1.c3", 1, 0, 8'h00, 0, 8'h00);

        // Cross writes and reads: responses go back to their own requester.
        drive(1, 1, 11'd0, 8'hFE, 0, 0, 0, 0);
        rdy("t2.wa", 1, 0);
        mem_if("t2.wa", 1, 1, 14'h0000, 16'h00FE);
        tick();
        drive(0, 0, 0, 0, 1, 1, 11'd1, 8'hDE);
        rdy("t2.wb", 0, 1);
        mem_if("t2.wb", 1, 1, 14'h0008, 16'h00DE);
        tick();
        drive(1, 0, 11'd1, 8'h00, 0, 0, 0, 0);
        rdy("t2.rc", 1, 0);
        mem_if("t2.rc", 1, 0, 14'h0008, 16'h0000);
        tick();
        drive(0, 0, 0, 0, 1, 0, 11'd0, 8'h00);
        rdy("t2.rd", 0, 1);
        tick();
        idle();
        rsp("t2.c1", 0, 1, 8'hDE, 0, 8'h00);
        rsp("t2.c1", 1, 0, 8'h00, 0, 8'h00);
        tick();
        rsp("t2.c2", 0, 0, 8'hDE, 1, 8'hFE);
        rsp("t2.c2", 1, 1, 8'hDE, 0, 8'h00);
        tick();
        rsp("t2.c3", 0, 0, 8'hDE, 0, 8'hFE);
        rsp("t2.c3", 1, 0, 8'hDE, 1, 8'hFE);
        tick();
        rsp("t2.c4", 1, 0, 8'hDE, 0, 8'hFE);

        // Contention for four cycles: last grant was requester 1, so 0,1,0,1.
        drive(1, 1, 11'd8, 8'h11, 1, 1, 11'd9, 8'h22);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                rdy($sformatf("t3.%0d", i), 1, 0);
                mem_if($sformatf("t3.%0d", i), 1, 1, 14'h0040, 16'h0011);
            end else begin
                rdy($sformatf("t3.%0d", i), 0, 1);
                mem_if($sformatf("t3.%0d", i), 1, 1, 14'h0048, 16'h0022);
            end
            tick();
        end

        // Back-to-back reads by requester 1.
        drive(0, 0, 0, 0, 1, 1, 11'd2, 8'hBE);
        rdy("t4.w2", 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 1, 11'd3, 8'hDA);
        rdy("t4.w3", 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 11'd2, 8'h00);
        rdy("t4.r2", 0, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, 11'd3, 8'h00);
        rdy("t4.r3", 0, 1);
        tick();
        idle();
        rsp("t4.c1", 0, 0, 8'hDE, 1, 8'hBE);
        rsp("t4.c1", 1, 0, 8'hDE, 0, 8'hFE);
        tick();
        rsp("t4.c2", 0, 0, 8'hDE, 1, 8'hDA);
        rsp("t4.c2", 1, 0, 8'hDE, 1, 8'hBE);
        tick();
        rsp("t4.c3", 0, 0, 8'hDE, 0, 8'hDA);
        rsp("t4.c3", 1, 0, 8'hDE, 1, 8'hDA);
        tick();
        rsp("t4.c4", 1, 0, 8'hDE, 0, 8'hDA);

        // Reset one cycle after a read transfer: the read is dropped.
        chk("t5.mrst_pre", mrst[0], 1'b0);
        drive(1, 0, 11'd2, 8'h00, 0, 0, 0, 0);
        rdy("t5.r", 1, 0);
        tick();
        RESETN = 1'b0;
        #1;
        rdy("t5.gated", 0, 0);
        mem_if("t5.gated", 0, 0, 0, 0);
        tick();
        reset_state("t5.r1");
        tick();
        reset_state("t5.r2");

        // After re-init, contention is won by requester 0 again; memory kept or cleared.
        RESETN = 1'b1;
        drive(1, 0, 11'd2, 8'h00, 1, 0, 11'd3, 8'h00);
        wait_init("t6");
        rdy("t6.a", 1, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 11'd3, 8'h00);
        rdy("t6.b", 0, 1);
        tick();
        idle();
        rsp("t6.c1", 0, 1, x0, 0, 8'h00);
        rsp("t6.c1", 1, 0, 8'h00, 0, 8'h00);
        tick();
        rsp("t6.c2", 0, 0, x0, 1, x1);
        rsp("t6.c2", 1, 1, x0, 0, 8'h00);
        tick();
        rsp("t6.c3", 0, 0, x0, 0, x1);
        rsp("t6.c3", 1, 0, x0, 1, x1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
